// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: PC holder and sequential instruction prefetcher.
// Issues reads to a 1-cycle-latency synchronous instruction memory, buffers
// the returned {instr, pc} pairs in a FIFO_DEPTH-entry queue and hands them
// to decode over valid/ready. A redirect flushes the queue and the read in
// flight.
// Optional build macro: IF_PREFETCH_PERF_EN adds perf_fetch_cnt and
// perf_flush_cnt output ports.
module if_prefetch_stage #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PC_STEP    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;  // holds 0..FIFO_DEPTH
  localparam int unsigned OCC_W = PTR_W + 2;  // count + inflight without overflow

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_q    [FIFO_DEPTH];

  logic              pop;
  logic              push;
  logic [OCC_W-1:0]  occ;

  // Handshake, issue credit and head presentation
  always_comb begin
    out_valid = (count_q != '0);
    out_instr = instr_q[rd_ptr_q];
    out_pc    = pc_q[rd_ptr_q];
    pop       = out_valid && out_ready;
    push      = inflight_q && !redirect_valid;
    occ       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    // rst_n gate keeps the strobe low while the block is held in reset
    imem_req  = rst_n && !redirect_valid && (occ < OCC_W'(FIFO_DEPTH));
    imem_addr = fetch_pc_q;
  end

  // Next-state for PC, in-flight tag, pointers and occupancy
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage: capture the returning word with its tagged PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // The pop credit guarantees a full queue never receives a response
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Delivered-instruction and discarded-work counters
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    if (redirect_valid) begin
      perf_flush_d = perf_flush_q + 32'(count_q) + 32'(inflight_q);
    end else if (pop) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: per-cycle vector table plus
// hand-written sequences for asynchronous reset and PC wrap-around.
module tb_if_prefetch_stage;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rdata = '0;
  logic          w_valid;
  logic [DW-1:0] w_instr;
  logic [AW-1:0] w_pc;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
  logic [31:0] w_perf_fetch, w_perf_flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  if_prefetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (1'b0),
    .redirect_pc    ('0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_rdata     (w_rdata),
    .out_valid      (w_valid),
    .out_ready      (1'b1),
    .out_instr      (w_instr),
    .out_pc         (w_pc)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (w_perf_fetch),
    .perf_flush_cnt (w_perf_flush)
`endif
  );

  // Synchronous instruction memories: word = address ^ XORK, 1-cycle latency
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ XORK;
    if (w_req)    w_rdata    <= w_addr ^ XORK;
  end

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    int          fetch;
    int          flush;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rdy, bit redir, logic [31:0] rpc,
                              bit req, logic [31:0] addr, bit vld, logic [31:0] pc,
                              int fetch = -1, int flush = -1);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    v.fetch = fetch; v.flush = flush;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  // Hold reset for one cycle, check reset outputs, release at a falling edge
  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_req",   -1, 32'(imem_req),  32'd0);
    chk("rst_valid", -1, 32'(out_valid), 32'd0);
    chk("rst_pc",    -1, out_pc,         32'd0);
    chk("rst_instr", -1, out_instr,      32'd0);
`ifdef IF_PREFETCH_PERF_EN
    chk("rst_perf_fetch", -1, perf_fetch_cnt, 32'd0);
    chk("rst_perf_flush", -1, perf_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] wexp [4];
    logic [31:0] wgot [4];
    int          nw;

    // Sequential stream, no stall
    tbl.push_back(mk(1,1,0,0, 1,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h04,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h08,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0C,1,32'h4));
    tbl.push_back(mk(0,1,0,0, 1,32'h10,1,32'h8, 2, 0));
    // Stall from cycle 0: exactly FIFO_DEPTH reads, then resume
    tbl.push_back(mk(1,0,0,0, 1,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h04,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h08,1,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h0C,1,32'h0));
    tbl.push_back(mk(0,0,0,0, 0,32'h10,1,32'h0));
    tbl.push_back(mk(0,0,0,0, 0,32'h10,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h10,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h14,1,32'h4));
    tbl.push_back(mk(0,1,0,0, 1,32'h18,1,32'h8));
    tbl.push_back(mk(0,1,0,0, 1,32'h1C,1,32'hC));
    tbl.push_back(mk(0,1,0,0, 1,32'h20,1,32'h10));
    tbl.push_back(mk(0,1,0,0, 1,32'h24,1,32'h14));
    // Redirect to 0x100 with 3 queued + 1 in flight
    tbl.push_back(mk(1,0,0,0,        1,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0,        1,32'h04,0,0));
    tbl.push_back(mk(0,0,0,0,        1,32'h08,1,32'h0));
    tbl.push_back(mk(0,0,0,0,        1,32'h0C,1,32'h0));
    tbl.push_back(mk(0,0,1,32'h100,  0,32'h10,1,32'h0));
    tbl.push_back(mk(0,1,0,0,        1,32'h100,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h104,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h108,1,32'h100));
    tbl.push_back(mk(0,1,0,0,        1,32'h10C,1,32'h104, 1, 4));
    // Redirect during pop+push, then another redirect next cycle
    tbl.push_back(mk(1,1,0,0,        1,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h04,0,0));
    tbl.push_back(mk(0,1,1,32'h300,  0,32'h08,1,32'h0));
    tbl.push_back(mk(0,1,1,32'h200,  0,32'h300,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h200,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h204,0,0));
    tbl.push_back(mk(0,1,0,0,        1,32'h208,1,32'h200));
    tbl.push_back(mk(0,1,0,0,        1,32'h20C,1,32'h204, 1, 2));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) apply_reset();
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      #1;
      chk("imem_req",  i, 32'(imem_req),  32'(tbl[i].req));
      chk("imem_addr", i, imem_addr,      tbl[i].addr);
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("out_pc",    i, out_pc,    tbl[i].pc);
        chk("out_instr", i, out_instr, tbl[i].pc ^ XORK);
      end
`ifdef IF_PREFETCH_PERF_EN
      if (tbl[i].fetch >= 0) chk("perf_fetch", i, perf_fetch_cnt, 32'(tbl[i].fetch));
      if (tbl[i].flush >= 0) chk("perf_flush", i, perf_flush_cnt, 32'(tbl[i].flush));
`endif
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset mid-stream with 2 entries queued
    apply_reset();
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_valid_before", 100, 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid",  101, 32'(out_valid), 32'd0);
    chk("mid_req",    101, 32'(imem_req),  32'd0);
    chk("mid_pc",     101, out_pc,         32'd0);
    chk("mid_instr",  101, out_instr,      32'd0);
`ifdef IF_PREFETCH_PERF_EN
    chk("mid_perf_fetch", 101, perf_fetch_cnt, 32'd0);
    chk("mid_perf_flush", 101, perf_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("restart_req",  102, 32'(imem_req), 32'd1);
    chk("restart_addr", 102, imem_addr,     32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("restart_valid", 103, 32'(out_valid), 32'd1);
    chk("restart_pc",    103, out_pc,         32'h0);
    @(negedge clk);

    // PC wrap-around on the RESET_PC=FFFF_FFF8 instance
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;
    apply_reset();
    nw = 0;
    for (int c = 0; c < 12 && nw < 4; c++) begin
      #1;
      if (w_valid) begin
        wgot[nw] = w_pc;
        nw++;
      end
      @(negedge clk);
    end
    chk("wrap_count", 200, 32'(nw), 32'd4);
    for (int k = 0; k < nw; k++) chk("wrap_pc", 200 + k, wgot[k], wexp[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
